// File: rtl/shift_pkg.sv
// Shared definitions for the shift request arbiter.
// Op codes and output-register FSM encoding.
package shift_pkg;

  localparam logic [1:0] OP_ROTL = 2'b00;
  localparam logic [1:0] OP_ROTR = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_SHR  = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational log-stage barrel shifter: din, amt, op -> dout.
// Ops: rotl, rotr, logical shl, logical shr.
module barrel_shift_core
  import shift_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] amt,
  input  logic [1:0]    op,
  output logic [W-1:0]  dout
);

  logic [SW:0][W-1:0] st;

  assign st[0] = din;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [W-1:0] sh;

    always_comb begin
      sh = st[k];
      case (op)
        OP_ROTL: sh = (st[k] << S) | (st[k] >> (W - S));
        OP_ROTR: sh = (st[k] >> S) | (st[k] << (W - S));
        OP_SHL:  sh = st[k] << S;
        OP_SHR:  sh = st[k] >> S;
        default: sh = st[k];
      endcase
    end

    assign st[k+1] = amt[k] ? sh : st[k];
  end

  assign dout = st[SW];

endmodule

// File: rtl/shift_req_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NREQ requesters.
// req_* in (valid/data/amt/op), req_ready out; registered out_* valid/ready channel.
module shift_req_arbiter
  import shift_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int W    = 8,
  localparam int SW   = $clog2(W),
  localparam int SRCW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ*SW-1:0] req_amt,
  input  logic [NREQ*2-1:0] req_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [SRCW-1:0]   out_src
);

  state_t            state, state_nxt;
  logic [SRCW-1:0]   rr_ptr;
  logic [NREQ-1:0]   gnt;
  logic [SRCW-1:0]   gidx;
  logic              found;
  logic              can_load;
  logic              xfer;
  logic [W-1:0]      sel_data;
  logic [SW-1:0]     sel_amt;
  logic [1:0]        sel_op;
  logic [W-1:0]      shifted;

  // Search upward from rr_ptr, wrapping, for the first valid requester.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gidx     = SRCW'(idx);
      end
    end
  end

  assign can_load  = (state == ST_EMPTY) | out_ready;
  // Gated by rst so nothing is accepted while reset is held.
  assign req_ready = (can_load && !rst) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  assign sel_data = req_data[gidx*W +: W];
  assign sel_amt  = req_amt[gidx*SW +: SW];
  assign sel_op   = req_op[gidx*2 +: 2];

  barrel_shift_core #(
    .W  (W),
    .SW (SW)
  ) u_core (
    .din  (sel_data),
    .amt  (sel_amt),
    .op   (sel_op),
    .dout (shifted)
  );

  always_comb begin
    state_nxt = state;
    if (xfer)
      state_nxt = ST_FULL;
    else if (state == ST_FULL && out_ready)
      state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_EMPTY;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= '0;
    end else if (xfer) begin
      out_data <= shifted;
      out_src  <= gidx;
      if (int'(gidx) == NREQ - 1)
        rr_ptr <= '0;
      else
        rr_ptr <= gidx + 1'b1;
    end
  end

  assign out_valid = (state == ST_FULL);

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Directed testbench for shift_req_arbiter (NREQ=2, W=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shift_req_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_data;
  logic [5:0]  req_amt;
  logic [3:0]  req_op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [0:0]  out_src;

  int checks;
  int failures;

  shift_req_arbiter #(
    .NREQ (2),
    .W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [7:0] d,
                         input logic [2:0] a, input logic [1:0] o);
    req_data[i*8 +: 8] = d;
    req_amt[i*3 +: 3]  = a;
    req_op[i*2 +: 2]   = o;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 2'b11;
    out_ready = 1'b1;
    req_data  = '0;
    req_amt   = '0;
    req_op    = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h exp=00", out_data);
    end
    checks++;
    if (out_src !== 1'b0) begin
      failures++;
      $display("FAIL reset_src got=%h exp=0", out_src);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=00", req_ready);
    end
    rst       = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_req0;
    set_req(0, 8'h0B, 3'd3, 2'b00);
    req_valid = 2'b01;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL req0_ready got=%b exp=01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h58 || out_src !== 1'b0) begin
      failures++;
      $display("FAIL req0_result got=%b/%h/%h exp=1/58/0",
               out_valid, out_data, out_src);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL req0_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_req1;
    logic [7:0] din [3];
    logic [2:0] amt [3];
    logic [1:0] op  [3];
    logic [7:0] exp [3];
    din = '{8'h51, 8'hFF, 8'hFF};
    amt = '{3'd1, 3'd7, 3'd4};
    op  = '{2'b01, 2'b11, 2'b10};
    exp = '{8'hA8, 8'h01, 8'hF0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1, din[i], amt[i], op[i]);
      req_valid = 2'b10;
      @(negedge clk);
      req_valid = 2'b00;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_src !== 1'b1) begin
        failures++;
        $display("FAIL req1_vec%0d got=%b/%h/%h exp=1/%h/1",
                 i, out_valid, out_data, out_src, exp[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 8'h01, 3'd1, 2'b10);
    set_req(1, 8'h80, 3'd1, 2'b11);
    req_valid = 2'b11;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_src !== 1'(i % 2) ||
          out_data !== ((i % 2) == 0 ? 8'h02 : 8'h40)) begin
        failures++;
        $display("FAIL b2b_%0d got=%b/%h/%h exp=1/%h/%0d", i,
                 out_valid, out_data, out_src,
                 ((i % 2) == 0 ? 8'h02 : 8'h40), i % 2);
      end
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL stall_ready0 got=%b exp=00", req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_src !== 1'b1 ||
          out_data !== 8'h40 || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL stall_%0d got=%b/%h/%h/%b exp=1/40/1/00",
                 i, out_valid, out_data, out_src, req_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL stall_release_ready got=%b exp=01", req_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h02) begin
      failures++;
      $display("FAIL stall_resume0 got=%b/%h/%h exp=1/02/0",
               out_valid, out_data, out_src);
    end
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== 8'h40) begin
      failures++;
      $display("FAIL stall_resume1 got=%b/%h/%h exp=1/40/1",
               out_valid, out_data, out_src);
    end
    @(negedge clk);
  endtask

  task automatic test_amt0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 8'hA5, 3'd0, 2'(i));
      req_valid = 2'b01;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 1'b0) begin
        failures++;
        $display("FAIL amt0_op%0d got=%b/%h/%h exp=1/a5/0",
                 i, out_valid, out_data, out_src);
      end
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    set_req(0, 8'h0B, 3'd3, 2'b00);
    set_req(1, 8'h80, 3'd1, 2'b11);
    req_valid = 2'b01;
    out_ready = 1'b1;
    @(negedge clk);
    req_valid = 2'b00;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h58) begin
      failures++;
      $display("FAIL rstmid_pre got=%b/%h exp=1/58", out_valid, out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_async got=%b/%h/%b exp=0/00/00",
               out_valid, out_data, req_ready);
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b11;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_grant got=%b exp=01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h58) begin
      failures++;
      $display("FAIL rstmid_first got=%b/%h/%h exp=1/58/0",
               out_valid, out_data, out_src);
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_req0;
    test_req1;
    test_back_to_back;
    test_stall;
    test_amt0;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
